// File: rtl/rv32i_pkg.sv
// Shared constants for the RV32I memory stage: opcodes, load/store size codes, FSM states.
// The misalignment helper is only referenced when RV32I_MISALIGN_TRAP_EN is defined.
package rv32i_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // funct3 codes; SB/SH/SW share the B/H/W encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      2'b01:   return addr[0];
      2'b10:   return (addr != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_load_align.sv
// Load lane extraction: picks the byte/halfword addressed within the bus word
// and sign- or zero-extends it according to funct3.
module rv32i_load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_data = {24'h0, w_byte};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/rv32i_memtop.sv
// RV32I memory-access stage: req/ack data-bus handshake with byte-lane steering,
// upstream stall and decode forwarding. Optional trap on misaligned access: RV32I_MISALIGN_TRAP_EN.
module rv32i_memtop
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] pc_in,
  input  logic [4:0]  wb_reg_in,
  input  logic        wb_en_in,
  input  logic        w_en_in,
  input  logic [31:0] rs2_data_in,
  output logic [31:0] d_addr,
  output logic [31:0] d_wdata,
  output logic [3:0]  d_be,
  output logic        d_we,
  output logic        d_req,
  input  logic        d_ack,
  input  logic [31:0] d_rdata,
  output logic        stall_out,
  output logic [31:0] alu_out,
  output logic [31:0] iw_out,
  output logic [31:0] pc_out,
  output logic [4:0]  wb_reg_out,
  output logic        wb_en_out,
  output logic        misalign_out,
  output logic        df_mem_enable,
  output logic [4:0]  df_mem_reg,
  output logic [31:0] df_mem_data
);

  mem_state_t  r_state;
  logic [31:0] r_addr, r_wdata, r_iw, r_pc;
  logic [3:0]  r_be;
  logic        r_we, r_wb_en;
  logic [4:0]  r_wb_reg;
  logic [31:0] r_alu_out, r_iw_out, r_pc_out;
  logic [4:0]  r_wb_reg_out;
  logic        r_wb_en_out;

  logic        w_is_load, w_is_store, w_is_mem, w_trap, w_busy, w_r_is_load;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ld_data;

  assign w_is_load   = (iw_in[6:0] == OP_LOAD);
  assign w_is_store  = (iw_in[6:0] == OP_STORE);
  assign w_is_mem    = w_is_load | w_is_store;
  assign w_busy      = (r_state == ST_BUSY);
  assign w_r_is_load = (r_iw[6:0] == OP_LOAD);

`ifdef RV32I_MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_trap       = w_is_mem & misaligned(iw_in[13:12], alu_in[1:0]);
  assign misalign_out = r_misalign;
`else
  assign w_trap       = 1'b0;
  assign misalign_out = 1'b0;
`endif

  // Store lane steering from the incoming address and size
  always_comb begin
    case (iw_in[13:12])
      2'b00: begin
        w_be    = 4'b0001 << alu_in[1:0];
        w_wdata = {4{rs2_data_in[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {alu_in[1], 1'b0};
        w_wdata = {2{rs2_data_in[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = rs2_data_in;
      end
    endcase
  end

  rv32i_load_align u_load_align (
    .i_rdata  (d_rdata),
    .i_addr   (r_addr[1:0]),
    .i_funct3 (r_iw[14:12]),
    .o_data   (w_ld_data)
  );

  assign d_req     = w_busy;
  assign d_we      = w_busy & r_we;
  assign d_be      = w_busy ? r_be : 4'b0000;
  assign d_addr    = {r_addr[31:2], 2'b00};
  assign d_wdata   = r_wdata;
  assign stall_out = reset & (w_busy ? ~d_ack : (w_is_mem & ~w_trap));

  always_comb begin
    df_mem_enable = 1'b0;
    df_mem_reg    = 5'd0;
    df_mem_data   = 32'd0;
    if (!reset) begin
      df_mem_enable = 1'b0;
    end else if (w_busy) begin
      if (w_r_is_load && d_ack && r_wb_en) begin
        df_mem_enable = 1'b1;
        df_mem_reg    = r_wb_reg;
        df_mem_data   = w_ld_data;
      end
    end else if (!w_is_load) begin
      df_mem_enable = wb_en_in;
      df_mem_reg    = wb_reg_in;
      df_mem_data   = alu_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_iw         <= 32'd0;
      r_pc         <= 32'd0;
      r_be         <= 4'd0;
      r_we         <= 1'b0;
      r_wb_reg     <= 5'd0;
      r_wb_en      <= 1'b0;
      r_alu_out    <= 32'd0;
      r_iw_out     <= 32'd0;
      r_pc_out     <= 32'd0;
      r_wb_reg_out <= 5'd0;
      r_wb_en_out  <= 1'b0;
`ifdef RV32I_MISALIGN_TRAP_EN
      r_misalign   <= 1'b0;
`endif
    end else begin
`ifdef RV32I_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
`ifdef RV32I_MISALIGN_TRAP_EN
          if (w_trap) begin
            r_alu_out    <= alu_in;
            r_iw_out     <= 32'd0;
            r_pc_out     <= pc_in;
            r_wb_reg_out <= wb_reg_in;
            r_wb_en_out  <= 1'b0;
            r_misalign   <= 1'b1;
          end else
`endif
          if (w_is_mem) begin
            r_addr       <= alu_in;
            r_wdata      <= w_wdata;
            r_be         <= w_be;
            r_we         <= w_is_store & w_en_in;
            r_iw         <= iw_in;
            r_pc         <= pc_in;
            r_wb_reg     <= wb_reg_in;
            r_wb_en      <= wb_en_in;
            r_alu_out    <= 32'd0;
            r_iw_out     <= 32'd0;
            r_pc_out     <= 32'd0;
            r_wb_reg_out <= 5'd0;
            r_wb_en_out  <= 1'b0;
            r_state      <= ST_BUSY;
          end else begin
            r_alu_out    <= alu_in;
            r_iw_out     <= iw_in;
            r_pc_out     <= pc_in;
            r_wb_reg_out <= wb_reg_in;
            r_wb_en_out  <= wb_en_in;
          end
        end
        ST_BUSY: begin
          // Output registers keep the bubble until the bus completes
          if (d_ack) begin
            r_alu_out    <= w_r_is_load ? w_ld_data : r_addr;
            r_iw_out     <= r_iw;
            r_pc_out     <= r_pc;
            r_wb_reg_out <= r_wb_reg;
            r_wb_en_out  <= r_wb_en;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign alu_out    = r_alu_out;
  assign iw_out     = r_iw_out;
  assign pc_out     = r_pc_out;
  assign wb_reg_out = r_wb_reg_out;
  assign wb_en_out  = r_wb_en_out;

endmodule

// File: tb/tb_rv32i_memtop.sv
// Randomized bench for rv32i_memtop against a transaction-level model of the stage;
// covers the misaligned-trap behaviour when RV32I_MISALIGN_TRAP_EN is defined.
module tb_rv32i_memtop;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] alu_in = '0, iw_in = '0, pc_in = '0, rs2_data_in = '0, d_rdata = '0;
  logic [4:0]  wb_reg_in = '0;
  logic        wb_en_in = 1'b0, w_en_in = 1'b0, d_ack = 1'b0;
  logic [31:0] d_addr, d_wdata, alu_out, iw_out, pc_out, df_mem_data;
  logic [3:0]  d_be;
  logic        d_we, d_req, stall_out, wb_en_out, misalign_out, df_mem_enable;
  logic [4:0]  wb_reg_out, df_mem_reg;

  int n_checks = 0;
  int n_errors = 0;

  rv32i_memtop dut (
    .clk(clk), .reset(reset), .alu_in(alu_in), .iw_in(iw_in), .pc_in(pc_in),
    .wb_reg_in(wb_reg_in), .wb_en_in(wb_en_in), .w_en_in(w_en_in), .rs2_data_in(rs2_data_in),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be), .d_we(d_we), .d_req(d_req),
    .d_ack(d_ack), .d_rdata(d_rdata), .stall_out(stall_out), .alu_out(alu_out),
    .iw_out(iw_out), .pc_out(pc_out), .wb_reg_out(wb_reg_out), .wb_en_out(wb_en_out),
    .misalign_out(misalign_out), .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg),
    .df_mem_data(df_mem_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'b00:   return 4'(1 << (a % 4));
      2'b01:   return 4'(3 << (a & 2));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] v);
    case (f3[1:0])
      2'b00:   return (v & 32'hFF) * 32'h0101_0101;
      2'b01:   return (v & 32'hFFFF) * 32'h0001_0001;
      default: return v;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: begin
        v = (rd >> (8 * (a % 4))) & 32'hFF;
        if (f3 == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic run_nonmem(input logic [31:0] iw, input logic [31:0] alu, input logic [31:0] pc,
                            input logic [4:0] rd, input logic en);
    iw_in = iw; alu_in = alu; pc_in = pc; wb_reg_in = rd; wb_en_in = en; w_en_in = 1'b0;
    rs2_data_in = $urandom();
    #1;
    chk("alu_stall", stall_out, 0);
    chk("alu_df_en", df_mem_enable, en);
    chk("alu_df_reg", df_mem_reg, rd);
    chk("alu_df_data", df_mem_data, alu);
    @(posedge clk); @(negedge clk);
    chk("alu_out", alu_out, alu);
    chk("alu_iw_out", iw_out, iw);
    chk("alu_pc_out", pc_out, pc);
    chk("alu_wb_reg_out", wb_reg_out, rd);
    chk("alu_wb_en_out", wb_en_out, en);
    chk("alu_req", d_req, 0);
  endtask

  task automatic run_mem(input logic [31:0] iw, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [4:0] rd, input logic en,
                         input logic [31:0] rdata, input int k);
    logic       ld;
    logic [2:0] f3;
    int         stalls;
`ifdef RV32I_MISALIGN_TRAP_EN
    logic       mis;
`endif
    ld = (iw[6:0] == OPC_LOAD);
    f3 = iw[14:12];
    iw_in = iw; alu_in = addr; rs2_data_in = rs2; pc_in = pc;
    wb_reg_in = rd; wb_en_in = en; w_en_in = !ld;
    #1;
`ifdef RV32I_MISALIGN_TRAP_EN
    mis = (f3[1:0] == 2'b01 && addr % 2 != 0) || (f3[1:0] == 2'b10 && addr % 4 != 0);
    if (mis) begin
      chk("trap_stall", stall_out, 0);
      @(posedge clk); @(negedge clk);
      chk("trap_flag", misalign_out, 1);
      chk("trap_wb_en", wb_en_out, 0);
      chk("trap_iw", iw_out, 0);
      chk("trap_req", d_req, 0);
      return;
    end
`endif
    stalls = int'(stall_out);
    if (ld) chk("ld_df_idle", df_mem_enable, 0);
    @(posedge clk); @(negedge clk);
    chk("bubble_iw", iw_out, 0);
    chk("bubble_wb_en", wb_en_out, 0);
    for (int j = 1; j < k; j++) begin
      chk("req_wait", d_req, 1);
      stalls += int'(stall_out);
      if (ld) chk("ld_df_wait", df_mem_enable, 0);
      @(posedge clk); @(negedge clk);
    end
    d_ack = 1'b1; d_rdata = rdata;
    #1;
    chk("req", d_req, 1);
    chk("addr", d_addr, addr & ~32'h3);
    chk("be", d_be, exp_be(f3, addr));
    chk("we", d_we, !ld);
    if (!ld) chk("wdata", d_wdata, exp_wdata(f3, rs2));
    chk("stall_ack", stall_out, 0);
    chk("stall_cycles", stalls, k);
    if (ld) begin
      chk("ld_df_en", df_mem_enable, 1);
      chk("ld_df_reg", df_mem_reg, rd);
      chk("ld_df_data", df_mem_data, exp_load(f3, addr, rdata));
    end
    @(posedge clk); @(negedge clk);
    d_ack = 1'b0; d_rdata = $urandom();
    chk(ld ? "ld_alu_out" : "st_alu_out", alu_out, ld ? exp_load(f3, addr, rdata) : addr);
    chk("mem_iw_out", iw_out, iw);
    chk("mem_pc_out", pc_out, pc);
    chk("mem_wb_reg_out", wb_reg_out, rd);
    chk("mem_wb_en_out", wb_en_out, en);
    chk("mem_req_done", d_req, 0);
    chk("mem_misalign", misalign_out, 0);
  endtask

  initial begin
    logic [31:0] r, iw, addr;
    logic [2:0]  f3;
    logic [6:0]  ops [4];
    logic [2:0]  lf3 [5];
    int          kind;
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0110111; ops[3] = 7'b0010111;
    lf3[0] = 3'b000; lf3[1] = 3'b001; lf3[2] = 3'b010; lf3[3] = 3'b100; lf3[4] = 3'b101;

    // Reset held with a load presented at the inputs
    @(negedge clk);
    iw_in = {12'h0, 5'd1, 3'b010, 5'd4, OPC_LOAD}; alu_in = 32'h40; wb_en_in = 1'b1; wb_reg_in = 5'd4;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_iw_out", iw_out, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_wb_reg_out", wb_reg_out, 0);
    chk("rst_wb_en_out", wb_en_out, 0);
    chk("rst_req", d_req, 0);
    chk("rst_we", d_we, 0);
    chk("rst_be", d_be, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_misalign", misalign_out, 0);
    chk("rst_df_en", df_mem_enable, 0);
    reset = 1'b1;

    run_nonmem({7'h0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 32'h0000_0005, 32'h100, 5'd3, 1'b1);
    run_mem({12'h0, 5'd1, 3'b000, 5'd5, OPC_LOAD}, 32'h103, 32'h0, 32'h104, 5'd5, 1'b1,
            32'h80FF_FF7F, 3);
    run_mem({12'h0, 5'd1, 3'b101, 5'd6, OPC_LOAD}, 32'h102, 32'h0, 32'h108, 5'd6, 1'b1,
            32'h8001_1234, 1);
    run_mem({7'h0, 5'd2, 5'd1, 3'b000, 5'd1, OPC_STORE}, 32'h201, 32'h0000_00AB, 32'h10C, 5'd0,
            1'b0, 32'h0, 2);
    run_mem({12'h0, 5'd1, 3'b010, 5'd7, OPC_LOAD}, 32'h102, 32'h0, 32'h110, 5'd7, 1'b1,
            32'hDEAD_BEEF, 1);

    // Reset while an access is outstanding
    iw_in = {12'h0, 5'd1, 3'b010, 5'd8, OPC_LOAD}; alu_in = 32'h300; wb_reg_in = 5'd8;
    wb_en_in = 1'b1; w_en_in = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort_req_before", d_req, 1);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    iw_in = 32'h0; alu_in = 32'h0; pc_in = 32'h0; wb_reg_in = 5'd0; wb_en_in = 1'b0;
    chk("abort_req_after", d_req, 0);
    d_ack = 1'b1; d_rdata = 32'h1234_5678;
    #1;
    chk("abort_stall", stall_out, 0);
    chk("abort_df_en", df_mem_enable, 0);
    @(posedge clk); @(negedge clk);
    d_ack = 1'b0;
    chk("abort_wb_en", wb_en_out, 0);
    chk("abort_iw", iw_out, 0);
    chk("abort_alu", alu_out, 0);

    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(0, 2));
      r = $urandom();
      addr = $urandom();
      if (kind == 0) begin
        iw = (r & 32'hFFFF_FF80) | {25'h0, ops[$urandom_range(0, 3)]};
        run_nonmem(iw, $urandom(), $urandom(), 5'($urandom()), 1'($urandom()));
      end else if (kind == 1) begin
        f3 = lf3[$urandom_range(0, 4)];
        iw = (r & ~32'h0000_707F) | {17'h0, f3, 12'h0} | {25'h0, OPC_LOAD};
        run_mem(iw, addr, $urandom(), $urandom(), 5'($urandom()), 1'b1, $urandom(),
                int'($urandom_range(1, 4)));
      end else begin
        f3 = lf3[$urandom_range(0, 2)];
        iw = (r & ~32'h0000_707F) | {17'h0, f3, 12'h0} | {25'h0, OPC_STORE};
        run_mem(iw, addr, $urandom(), $urandom(), 5'($urandom()), 1'($urandom()), $urandom(),
                int'($urandom_range(1, 4)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t limit 500000", $time);
    $fatal(1);
  end

endmodule
